pic_draw_ctrl: RTL and testbench

Sequencer and arbiter for the full-screen picture ROMs (opening, win, lose).
- Accepts one-cycle draw requests from the game FSM and grants one picture at a time by fixed priority.
- Scans the selected ROM in raster order and emits a pipelined pixel stream (plot, x, y, colour) to the VGA adapter.
- Sits between the game control FSM and the VGA adapter, alongside the brick/ball/paddle drawers.

---
 rtl/pic_pkg.sv | 22 ++
 rtl/pic_draw_ctrl_if.sv | 17 +
 rtl/pic_scan_counter.sv | 45 ++++
 rtl/pic_draw_ctrl.sv | 99 +++++++++
 tb/tb_pic_draw_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: picture ids, draw FSM encoding and screen defaults for the picture path
// Shared with the VGA adapter and the ROM wrapper; scan_t is one delay-pipeline entry.
package pic_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [1:0] PIC_OPENING = 2'd0;
  localparam logic [1:0] PIC_WIN = 2'd1;
  localparam logic [1:0] PIC_LOSE = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef struct packed {
    logic v;
    logic l;
    logic [7:0] x;
    logic [6:0] y;
  } scan_t;
  function automatic logic [1:0] pick(input logic [2:0] pend);
    return pend[2] ? PIC_LOSE : pend[1] ? PIC_WIN : PIC_OPENING;
  endfunction
endpackage

// File: rtl/pic_draw_ctrl_if.sv
// pic_draw_ctrl_if: ROM read bus plus pixel stream between the picture sequencer and its peers
// master (sequencer): drives rom_sel, rom_addr, plot, x, y, colour; samples rom_data.
// slave (ROM mux / VGA side): the mirror image.
interface pic_draw_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int COLOUR_W = 3
) ();
  logic [1:0] rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [COLOUR_W-1:0] colour;
  modport master(output rom_sel, rom_addr, plot, x, y, colour, input rom_data);
  modport slave(input rom_sel, rom_addr, plot, x, y, colour, output rom_data);
endinterface

// File: rtl/pic_scan_counter.sv
// pic_scan_counter: raster scan counter producing a linear address and (sx, sy)
// Ports: clk, resetn (sync, active-low), clr (restart at 0), en (advance one pixel),
// addr (linear address), sx/sy (column/row), last (currently at final pixel).
// The address is kept as its own incrementer alongside sx/sy so no multiplier is needed;
// it saturates at the last pixel instead of wrapping.
module pic_scan_counter #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        sx,
  output logic [6:0]        sy,
  output logic              last
);
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [7:0] sx_d, sx_q;
  logic [6:0] sy_d, sy_q;
  logic eol, step;
  always_comb begin
    eol = sx_q == 8'(WIDTH - 1);
    last = eol && sy_q == 7'(HEIGHT - 1);
    step = en && !last;
    addr_d = clr ? '0 : step ? addr_q + ADDR_W'(1) : addr_q;
    sx_d = clr ? '0 : step ? (eol ? 8'd0 : sx_q + 8'd1) : sx_q;
    sy_d = clr ? '0 : (step && eol) ? sy_q + 7'd1 : sy_q;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      addr_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      addr_q <= addr_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  assign addr = addr_q;
  assign sx = sx_q;
  assign sy = sy_q;
endmodule

// File: rtl/pic_draw_ctrl.sv
// pic_draw_ctrl: arbitrates picture draw requests and streams the chosen ROM to the VGA adapter
// Ports: clk, resetn (sync, active-low), req_opening/req_win/req_lose (one-cycle requests),
// bus (master: rom_sel, rom_addr, rom_data, plot, x, y, colour), busy, done, active_pic.
// Requests are sticky until granted; LOSE beats WIN beats OPENING. Scan position rides a
// ROM_LAT-deep pipeline so it lines up with rom_data, then one output register stage.
module pic_draw_ctrl
  import pic_pkg::*;
#(
  parameter int WIDTH = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int ADDR_W = 15,
  parameter int COLOUR_W = 3,
  parameter int ROM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_opening,
  input  logic                   req_win,
  input  logic                   req_lose,
  pic_draw_ctrl_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             active_pic
);
  logic [1:0] state_d, state_q, pic_d, pic_q;
  logic [2:0] pend_d, pend_q;
  logic grant, issue, scan_last;
  logic [ADDR_W-1:0] addr;
  logic [7:0] sx;
  logic [6:0] sy;
  scan_t pipe_d [ROM_LAT];
  scan_t pipe_q [ROM_LAT];
  scan_t tail;
  logic plot_d, plot_q, last_d, last_q;
  logic [7:0] x_d, x_q;
  logic [6:0] y_d, y_q;
  logic [COLOUR_W-1:0] colour_d, colour_q;
  pic_scan_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_scan (
    .clk(clk),
    .resetn(resetn),
    .clr(grant),
    .en(issue),
    .addr(addr),
    .sx(sx),
    .sy(sy),
    .last(scan_last)
  );
  always_comb begin
    issue = state_q == ST_ISSUE;
    grant = state_q == ST_IDLE && |pend_q;
    pic_d = grant ? pick(pend_q) : pic_q;
    // A request landing on its own grant edge re-sets the bit, so it is drawn again later
    pend_d = (pend_q & ~(grant ? 3'b001 << pic_d : 3'b000)) | {req_lose, req_win, req_opening};
    // DRAIN ends once the final pixel is on the outputs, tracked by the pipelined last flag
    state_d = state_q == ST_IDLE ? (grant ? ST_ISSUE : ST_IDLE)
            : state_q == ST_ISSUE ? (scan_last ? ST_DRAIN : ST_ISSUE)
            : state_q == ST_DRAIN ? (last_q ? ST_DONE : ST_DRAIN) : ST_IDLE;
    pipe_d = pipe_q;
    pipe_d[0] = '{v: issue, l: issue && scan_last, x: sx, y: sy};
    for (int k = 1; k < ROM_LAT; k++) pipe_d[k] = pipe_q[k-1];
    tail = pipe_q[ROM_LAT-1];
    plot_d = tail.v;
    last_d = tail.v && tail.l;
    x_d = tail.v ? tail.x : x_q;
    y_d = tail.v ? tail.y : y_q;
    colour_d = tail.v ? bus.rom_data : colour_q;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q <= ST_IDLE;
      pic_q <= '0;
      pend_q <= '0;
      for (int k = 0; k < ROM_LAT; k++) pipe_q[k] <= '0;
      plot_q <= 1'b0;
      last_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      pic_q <= pic_d;
      pend_q <= pend_d;
      pipe_q <= pipe_d;
      plot_q <= plot_d;
      last_q <= last_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
    end
  assign bus.rom_sel = pic_q;
  assign bus.rom_addr = addr;
  assign bus.plot = plot_q;
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign active_pic = pic_q;
  assign busy = state_q == ST_ISSUE || state_q == ST_DRAIN;
  assign done = state_q == ST_DONE;
endmodule

// File: tb/tb_pic_draw_ctrl.sv
// tb_pic_draw_ctrl: scoreboard bench for the picture sequencer at ROM latency 1 (dut_a) and 3 (dut_b)
module tb_pic_draw_ctrl;
  import pic_pkg::*;
  localparam int N = 160 * 120;
  typedef struct packed {
    logic [1:0] pic;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  logic resetn_a = 1'b0, resetn_b = 1'b0;
  logic ro_a = 1'b0, rw_a = 1'b0, rl_a = 1'b0, ro_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [1:0] ap_a, ap_b;
  pic_draw_ctrl_if #(.ADDR_W(15), .COLOUR_W(3)) bus_a ();
  pic_draw_ctrl_if #(.ADDR_W(15), .COLOUR_W(3)) bus_b ();
  pic_draw_ctrl #(.ROM_LAT(1)) dut_a (
    .clk(clk), .resetn(resetn_a), .req_opening(ro_a), .req_win(rw_a), .req_lose(rl_a),
    .bus(bus_a), .busy(busy_a), .done(done_a), .active_pic(ap_a)
  );
  pic_draw_ctrl #(.ROM_LAT(3)) dut_b (
    .clk(clk), .resetn(resetn_b), .req_opening(ro_b), .req_win(1'b0), .req_lose(1'b0),
    .bus(bus_b), .busy(busy_b), .done(done_b), .active_pic(ap_b)
  );
  // Model ROMs: colour = addr[2:0] ^ picture id, with 1 and 3 cycles of latency
  logic [2:0] rb [3];
  always @(posedge clk) begin
    bus_a.rom_data <= bus_a.rom_addr[2:0] ^ {1'b0, bus_a.rom_sel};
    rb[0] <= bus_b.rom_addr[2:0] ^ {1'b0, bus_b.rom_sel};
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign bus_b.rom_data = rb[2];
  logic plot_s [2], busy_s [2], done_s [2];
  logic [21:0] out_s [2];
  assign plot_s[0] = bus_a.plot;
  assign plot_s[1] = bus_b.plot;
  assign busy_s[0] = busy_a;
  assign busy_s[1] = busy_b;
  assign done_s[0] = done_a;
  assign done_s[1] = done_b;
  assign out_s[0] = {ap_a, bus_a.rom_sel, bus_a.x, bus_a.y, bus_a.colour};
  assign out_s[1] = {ap_b, bus_b.rom_sel, bus_b.x, bus_b.y, bus_b.colour};
  pix_t exp_q [2][$];
  int done_q [2][$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic pix_t mk(input logic [1:0] pic, input int i);
    return '{pic: pic, x: 8'(i % 160), y: 7'(i / 160), c: 3'(i % 8) ^ {1'b0, pic}};
  endfunction
  task automatic push(input int d, input logic [1:0] pic, input int n);
    for (int i = 0; i < n; i++) exp_q[d].push_back(mk(pic, i));
  endtask
  int start [2] = '{0, 0};
  int nplot [2] = '{0, 0};
  int want [2] = '{-1, -1};
  logic busy_p [2] = '{1'b0, 1'b0};
  pix_t e_mon;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_s[d] && !busy_p[d]) begin
        if (exp_q[d].size() == 0) chk($sformatf("dut%0d unexpected draw", d), 1, 0);
        if (want[d] >= 0) chk($sformatf("dut%0d grant gap", d), cyc, want[d]);
        want[d] = -1;
        start[d] = cyc;
        nplot[d] = 0;
      end
      if (plot_s[d]) begin
        if (exp_q[d].size() == 0) chk($sformatf("dut%0d unexpected plot", d), 1, 0);
        else begin
          e_mon = exp_q[d].pop_front();
          chk($sformatf("dut%0d pixel {pic,sel,x,y,col}", d), int'(out_s[d]),
              int'({e_mon.pic, e_mon.pic, e_mon.x, e_mon.y, e_mon.c}));
        end
        if (nplot[d] == 0) chk($sformatf("dut%0d first plot cycle", d), cyc - start[d], d ? 4 : 2);
        nplot[d]++;
      end
      if (done_s[d]) begin
        if (done_q[d].size() == 0) chk($sformatf("dut%0d unexpected done", d), 1, 0);
        else chk($sformatf("dut%0d done active_pic", d), 32'(d ? ap_b : ap_a), done_q[d].pop_front());
        chk($sformatf("dut%0d done cycle", d), cyc - start[d], N + (d ? 4 : 2));
        chk($sformatf("dut%0d plot count", d), nplot[d], N);
        chk($sformatf("dut%0d busy at done", d), 32'(busy_s[d]), 0);
        if (done_q[d].size() > 0) want[d] = cyc + 2;
      end
      busy_p[d] = busy_s[d];
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset a plot/busy/done", {29'd0, bus_a.plot, busy_a, done_a}, 0);
    chk("reset a rom_addr", 32'(bus_a.rom_addr), 0);
    chk("reset a outputs", int'(out_s[0]), 0);
    chk("reset b plot/busy/done", {29'd0, bus_b.plot, busy_b, done_b}, 0);
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    @(negedge clk);
    #1;
    push(0, PIC_OPENING, 5001);
    push(1, PIC_OPENING, N);
    done_q[1].push_back(0);
    ro_a = 1'b1;
    ro_b = 1'b1;
    @(negedge clk);
    #1;
    ro_a = 1'b0;
    ro_b = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    rw_a = 1'b1;
    @(negedge clk);
    #1;
    rw_a = 1'b0;
    for (int k = 0; k < 8000 && exp_q[0].size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("wait for pixel 5000", exp_q[0].size(), 0);
    resetn_a = 1'b0;
    @(negedge clk);
    #1;
    chk("abort plot/busy/done", {29'd0, bus_a.plot, busy_a, done_a}, 0);
    chk("abort rom_addr", 32'(bus_a.rom_addr), 0);
    resetn_a = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("idle after abort busy", 32'(busy_a), 0);
    push(0, PIC_WIN, N);
    push(0, PIC_OPENING, N);
    push(0, PIC_LOSE, N);
    done_q[0].push_back(1);
    done_q[0].push_back(0);
    done_q[0].push_back(2);
    rw_a = 1'b1;
    ro_a = 1'b1;
    @(negedge clk);
    #1;
    rw_a = 1'b0;
    ro_a = 1'b0;
    for (int k = 0; k < 40000 && exp_q[0].size() > N + N / 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("wait mid opening", 32'(exp_q[0].size() <= N + N / 2), 1);
    rl_a = 1'b1;
    @(negedge clk);
    #1;
    rl_a = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    rl_a = 1'b1;
    @(negedge clk);
    #1;
    rl_a = 1'b0;
    for (int k = 0; k < 60000 && (exp_q[0].size() != 0 || done_q[0].size() != 0); k++) begin
      @(negedge clk);
      #1;
    end
    chk("a pixels outstanding", exp_q[0].size(), 0);
    chk("a dones outstanding", done_q[0].size(), 0);
    repeat (10) @(negedge clk);
    #1;
    chk("a active_pic holds", 32'(ap_a), 2);
    chk("a busy at end", 32'(busy_a), 0);
    chk("b pixels outstanding", exp_q[1].size(), 0);
    chk("b dones outstanding", done_q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
